// File: rtl/gpio_input_conditioner.sv
// -----------------------------------------------------------------------------
// gpio_input_conditioner
//
// Purpose:
//   Conditions raw board inputs (switches, buttons) before they reach the
//   GPIO/UART wrapper. Each bit is processed independently:
//     1. It passes through a two-flop synchronizer.
//     2. A counter-based debounce accepts a change only after DEBOUNCE_CYCLES
//        consecutive stable cycles.
//     3. A one-cycle rise or fall strobe marks each accepted change.
//   The block also keeps a sticky rise-event mask with a valid/ready handshake,
//   and a wrapping count of accepted rise events.
//
// Parameters:
//   N_IN             number of conditioned inputs
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a change (>= 2)
//   CNT_W            width of press_cnt
//
// Ports:
//   clk         in   1      system clock
//   rst_n       in   1      asynchronous active-low reset
//   raw_in      in   N_IN   asynchronous raw pin levels
//   clean_out   out  N_IN   debounced levels
//   rise_pulse  out  N_IN   1-cycle strobe when a clean bit goes 0->1
//   fall_pulse  out  N_IN   1-cycle strobe when a clean bit goes 1->0
//   evt_valid   out  1      evt_mask is non-zero
//   evt_mask    out  N_IN   sticky OR of rise events since the last accept
//   evt_ready   in   1      consumer accepts evt_mask
//   press_cnt   out  CNT_W  total accepted rise events; wraps around
//   toggle_out  out  N_IN   only when GPIO_COND_TOGGLE_EN is defined: a
//                           latching push-button view, where bit i inverts on
//                           each rise_pulse[i]
//
// Build option:
//   GPIO_COND_TOGGLE_EN  adds the toggle_out port and its logic. When it is not
//                        defined, that port and logic are absent and all other
//                        behaviour is identical.
// -----------------------------------------------------------------------------
module gpio_input_conditioner #(
  parameter int N_IN            = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  raw_in,
  output logic [N_IN-1:0]  clean_out,
  output logic [N_IN-1:0]  rise_pulse,
  output logic [N_IN-1:0]  fall_pulse,
  output logic             evt_valid,
  output logic [N_IN-1:0]  evt_mask,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] press_cnt
`ifdef GPIO_COND_TOGGLE_EN
  ,
  output logic [N_IN-1:0]  toggle_out
`endif
);

  // The counter only needs to reach DEBOUNCE_CYCLES-1, so clog2 bits suffice.
  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DCNT_ONE  = DW'(1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [N_IN-1:0]  r_sync1;
  logic [N_IN-1:0]  r_sync2;
  state_e           r_state [N_IN];
  logic [DW-1:0]    r_dcnt  [N_IN];
  logic [N_IN-1:0]  r_clean;
  logic [N_IN-1:0]  r_rise;
  logic [N_IN-1:0]  r_fall;
  logic [N_IN-1:0]  r_evt_mask;
  logic             r_evt_valid;
  logic [CNT_W-1:0] r_press_cnt;

  // ---------------------------------------------------------------------------
  // Combinational next-state
  // ---------------------------------------------------------------------------
  state_e           w_state_nxt [N_IN];
  logic [DW-1:0]    w_dcnt_nxt  [N_IN];
  logic [N_IN-1:0]  w_commit;
  logic             w_accept;
  logic [N_IN-1:0]  w_evt_mask_nxt;
  logic [CNT_W-1:0] w_rise_cnt;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer. The first stage has no logic after it, so a
  // metastable value has a full cycle to resolve.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) assignments. All flops then
  // sample together at the clock edge, with no dependence on the order of
  // statements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= raw_in;
      r_sync2 <= r_sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-bit debounce FSM: next state and counter
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first. A path that forgets
  // an assignment then holds that default instead of inferring a latch.
  always_comb begin
    w_commit = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_state_nxt[i] = r_state[i];
      w_dcnt_nxt[i]  = '0;
      unique case (r_state[i])
        ST_STABLE: begin
          if (r_sync2[i] != r_clean[i]) begin
            w_state_nxt[i] = ST_PENDING;
            w_dcnt_nxt[i]  = DCNT_ONE;
          end
        end
        ST_PENDING: begin
          if (r_sync2[i] == r_clean[i]) begin
            // The input went back to the accepted level (a glitch), so the
            // change is dropped.
            w_state_nxt[i] = ST_STABLE;
          end else if (r_dcnt[i] == DCNT_LAST) begin
            w_state_nxt[i] = ST_STABLE;
            w_commit[i]    = 1'b1;
          end else begin
            w_dcnt_nxt[i]  = r_dcnt[i] + DCNT_ONE;
          end
        end
        default: begin
          w_state_nxt[i] = ST_STABLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Per-bit debounce FSM: state register, clean level and strobes
  // ---------------------------------------------------------------------------
  // NOTE: the per-bit state and counter arrays are small and hold control
  // state, so they are reset element by element. A mid-debounce reset must
  // discard the pending change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) begin
        r_state[i] <= ST_STABLE;
        r_dcnt[i]  <= '0;
      end
      r_clean <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_dcnt[i]  <= w_dcnt_nxt[i];
      end
      // A committing bit always flips, because a commit requires sync != clean.
      r_clean <= r_clean ^ w_commit;
      r_rise  <= w_commit & r_sync2;
      r_fall  <= w_commit & ~r_sync2;
    end
  end

  // ---------------------------------------------------------------------------
  // Event handshake and press counter
  // ---------------------------------------------------------------------------
  // A rise that arrives in the accept cycle is ORed in after the clear, so it
  // survives into the next mask.
  assign w_accept       = r_evt_valid & evt_ready;
  assign w_evt_mask_nxt = (r_evt_mask & ~{N_IN{w_accept}}) | r_rise;

  // Number of rising strobes this cycle, already reduced modulo 2^CNT_W.
  always_comb begin
    w_rise_cnt = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_rise_cnt = w_rise_cnt + CNT_W'(r_rise[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt_mask  <= '0;
      r_evt_valid <= 1'b0;
      r_press_cnt <= '0;
    end else begin
      r_evt_mask  <= w_evt_mask_nxt;
      // Valid is taken from the same next-mask value, so it always matches
      // evt_mask in the same cycle.
      r_evt_valid <= |w_evt_mask_nxt;
      r_press_cnt <= r_press_cnt + w_rise_cnt;
    end
  end

`ifdef GPIO_COND_TOGGLE_EN
  // ---------------------------------------------------------------------------
  // Latching push-button view
  // ---------------------------------------------------------------------------
  logic [N_IN-1:0] r_toggle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_toggle <= '0;
    end else begin
      r_toggle <= r_toggle ^ r_rise;
    end
  end

  assign toggle_out = r_toggle;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign clean_out  = r_clean;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign evt_mask   = r_evt_mask;
  assign evt_valid  = r_evt_valid;
  assign press_cnt  = r_press_cnt;

endmodule
